// File: rtl/datapath_pkg.sv
// Shared types and field positions for the execute/write-back sequencer.
// Instruction layout: op[15:12] rd[11:9] rs1[8:6] rs2[5:3], imm[7:0].
package datapath_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int ADDR_W_DEF  = 3;
   localparam int INSTR_W_DEF = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS1_MSB = 8;
   localparam int RS1_LSB = 6;
   localparam int RS2_MSB = 5;
   localparam int RS2_LSB = 3;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_LDI = 4'd8,
      OP_MOV = 4'd9
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_SETTLE
   } state_e;

   function automatic logic op_writes(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_MOV);
   endfunction

endpackage

// File: rtl/exec_writeback_alu.sv
// Combinational ALU: result, carry/borrow/shift-out and zero flag.
// LDI/MOV pass carry_in through unchanged.
module alu
   import datapath_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] imm,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              zero
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide      = '0;
      result    = '0;
      carry_out = carry_in;
      unique case (op)
         OP_ADD: begin
            wide      = {1'b0, opa} + {1'b0, opb};
            result    = wide[DATA_W-1:0];
            carry_out = wide[DATA_W];
         end
         // bit DATA_W of the widened difference is the borrow
         OP_SUB: begin
            wide      = {1'b0, opa} - {1'b0, opb};
            result    = wide[DATA_W-1:0];
            carry_out = wide[DATA_W];
         end
         OP_AND: begin
            result    = opa & opb;
            carry_out = 1'b0;
         end
         OP_OR: begin
            result    = opa | opb;
            carry_out = 1'b0;
         end
         OP_XOR: begin
            result    = opa ^ opb;
            carry_out = 1'b0;
         end
         OP_SHL: begin
            result    = {opa[DATA_W-2:0], 1'b0};
            carry_out = opa[DATA_W-1];
         end
         OP_SHR: begin
            result    = {1'b0, opa[DATA_W-1:1]};
            carry_out = opa[0];
         end
         OP_LDI: result = imm;
         OP_MOV: result = opa;
         default: ;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/exec_writeback.sv
// Multi-cycle read/execute/write sequencer wrapped around an 8x8 register file.
// SETTLE covers the file's two-edge write commit before the next read.
module exec_writeback
   import datapath_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [ADDR_W-1:0]  ra1,
   output logic [ADDR_W-1:0]  ra2,
   input  logic [DATA_W-1:0]  rd1,
   input  logic [DATA_W-1:0]  rd2,
   output logic [DATA_W-1:0]  wd3,
   output logic [ADDR_W-1:0]  wa3,
   output logic               we3,
   output logic               zero,
   output logic               carry,
   output logic               done,
   output logic               illegal
);

   state_e              state, state_nxt;
   logic [INSTR_W-1:0]  ir;
   logic [DATA_W-1:0]   opa, opb, result;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry, alu_zero;
   logic                zero_q, carry_q;
   logic [3:0]          op;
   logic                writes, legal;

   assign op     = ir[OP_MSB:OP_LSB];
   assign writes = op_writes(op);
   assign legal  = writes || (op == OP_NOP);

   assign ra1   = ir[RS1_MSB:RS1_LSB];
   assign ra2   = ir[RS2_MSB:RS2_LSB];
   assign wa3   = ir[RD_MSB:RD_LSB];
   assign wd3   = result;
   assign zero  = zero_q;
   assign carry = carry_q;

   alu #(.DATA_W(DATA_W)) u_alu (
      .opa       (opa),
      .opb       (opb),
      .op        (op),
      .imm       (ir[IMM_MSB:IMM_LSB]),
      .carry_in  (carry_q),
      .result    (alu_res),
      .carry_out (alu_carry),
      .zero      (alu_zero)
   );

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      we3         = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      unique case (state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_nxt = S_READ;
         end
         S_READ: state_nxt = S_EXEC;
         S_EXEC: begin
            if (writes) begin
               state_nxt = S_WRITE;
            end else begin
               done      = 1'b1;
               illegal   = !legal;
               state_nxt = S_IDLE;
            end
         end
         S_WRITE: begin
            we3       = 1'b1;
            state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ir      <= '0;
         opa     <= '0;
         opb     <= '0;
         result  <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && instr_valid) ir <= instr;
         if (state == S_READ) begin
            opa <= rd1;
            opb <= rd2;
         end
         if (state == S_EXEC && writes) begin
            result  <= alu_res;
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
         end
      end
   end

endmodule

// File: tb/tb_exec_writeback.sv
// Directed + random bench for exec_writeback with a behavioural register file
// and an instruction-level reference model.
module tb_exec_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [2:0]  ra1, ra2, wa3;
   logic [7:0]  rd1, rd2, wd3;
   logic        we3, zero, carry, done, illegal;

   int total = 0;
   int bad   = 0;

   // register file environment: commit one edge after sampling we3
   logic [7:0] rf [0:7] = '{default: 8'h00};
   logic       pend = 1'b0;
   logic [2:0] pa = 3'd0;
   logic [7:0] pd = 8'h00;

   // architectural reference state
   int mreg [0:7] = '{default: 0};
   int mcarry = 0;
   int mzero  = 0;

   exec_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .ra1         (ra1),
      .ra2         (ra2),
      .rd1         (rd1),
      .rd2         (rd2),
      .wd3         (wd3),
      .wa3         (wa3),
      .we3         (we3),
      .zero        (zero),
      .carry       (carry),
      .done        (done),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   assign rd1 = rf[ra1];
   assign rd2 = rf[ra2];

   always @(posedge clk) begin
      if (pend) rf[pa] <= pd;
      pend <= we3;
      pa   <= wa3;
      pd   <= wd3;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd,
                                       input int s1, input int s2);
      return {op[3:0], rd[2:0], s1[2:0], s2[2:0], 3'b000};
   endfunction

   function automatic logic [15:0] ldi(input int rd, input int imm);
      return {4'h8, rd[2:0], 1'b0, imm[7:0]};
   endfunction

   task automatic issue(input logic [15:0] w, input bit chain,
                        input logic [15:0] nxt);
      int op, rd, a, b, res, c, z, ill;
      bit wr;
      int we_n, we_cyc, done_n, done_cyc, ill_n, ill_cyc, rdy_cyc;
      logic [2:0] wa_seen;
      logic [7:0] wd_seen;
      op  = int'(w[15:12]);
      rd  = int'(w[11:9]);
      a   = mreg[w[8:6]];
      b   = mreg[w[5:3]];
      c   = mcarry;
      z   = mzero;
      res = 0;
      wr  = 1'b1;
      ill = (op > 9) ? 1 : 0;
      case (op)
         1: begin res = (a + b) % 256; c = (a + b) / 256; end
         2: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
         3: begin res = a & b; c = 0; end
         4: begin res = a | b; c = 0; end
         5: begin res = a ^ b; c = 0; end
         6: begin res = (a * 2) % 256; c = a / 128; end
         7: begin res = a / 2; c = a % 2; end
         8: res = int'(w[7:0]);
         9: res = a;
         default: wr = 1'b0;
      endcase
      if (wr) z = (res == 0) ? 1 : 0;

      check("ready_before_accept", instr_ready, 1);
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      we_n = 0; we_cyc = 0; done_n = 0; done_cyc = 0;
      ill_n = 0; ill_cyc = 0; rdy_cyc = 0;
      wa_seen = '0; wd_seen = '0;
      for (int k = 1; k <= 8 && rdy_cyc == 0; k++) begin
         @(negedge clk);
         if (we3) begin
            we_n++; we_cyc = k; wa_seen = wa3; wd_seen = wd3;
         end
         if (done) begin done_n++; done_cyc = k; end
         if (illegal) begin ill_n++; ill_cyc = k; end
         if (instr_ready) rdy_cyc = k;
         if (chain) begin
            instr = nxt; instr_valid = 1'b1;
         end else if (!instr_ready) begin
            instr = 16'($urandom); instr_valid = 1'($urandom);
         end else begin
            instr_valid = 1'b0;
         end
      end

      check("ready_interval", rdy_cyc, wr ? 5 : 3);
      check("we3_pulses", we_n, wr ? 1 : 0);
      check("done_pulses", done_n, 1);
      check("done_cycle", done_cyc, wr ? 4 : 2);
      check("illegal_pulses", ill_n, ill);
      if (ill != 0) check("illegal_with_done", ill_cyc, done_cyc);
      if (wr) begin
         check("we3_cycle", we_cyc, 3);
         check("wa3", wa_seen, rd);
         check("wd3", wd_seen, res);
      end
      check("zero", zero, z);
      check("carry", carry, c);

      if (wr) mreg[rd] = res;
      mcarry = c;
      mzero  = z;
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      repeat (2) @(negedge clk);
      check("rst_ready", instr_ready, 1);
      check("rst_we3", we3, 0);
      check("rst_wd3", wd3, 0);
      check("rst_wa3", wa3, 0);
      check("rst_ra1", ra1, 0);
      check("rst_ra2", ra2, 0);
      check("rst_flags", {zero, carry, done, illegal}, 0);
      rst = 1'b0;
      @(negedge clk);

      issue(ldi(1, 8'h05), 0, 16'h0);
      issue(ldi(1, 8'hFF), 0, 16'h0);
      issue(ldi(2, 8'h01), 0, 16'h0);
      issue(enc(1, 3, 1, 2), 0, 16'h0);
      issue(enc(2, 4, 2, 1), 0, 16'h0);
      issue(enc(3, 5, 1, 2), 0, 16'h0);

      issue(ldi(1, 8'h33), 1, ldi(2, 8'h44));
      issue(ldi(2, 8'h44), 1, ldi(3, 8'h55));
      issue(ldi(3, 8'h55), 0, 16'h0);
      issue(enc(9, 6, 3, 0), 0, 16'h0);
      issue(enc(4, 3, 3, 3), 0, 16'h0);
      issue(enc(6, 0, 3, 0), 0, 16'h0);

      issue(16'hF000, 0, 16'h0);
      issue(16'h0000, 0, 16'h0);

      // set carry, then reset in the middle of a write to r7
      issue(ldi(1, 8'hFF), 0, 16'h0);
      issue(ldi(2, 8'h01), 0, 16'h0);
      issue(enc(1, 0, 1, 2), 0, 16'h0);
      issue(ldi(7, 8'h11), 0, 16'h0);
      check("pre_rst_carry", carry, 1);
      instr       = ldi(7, 8'hAA);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_we3_high", we3, 1);
      rst = 1'b1;
      #1;
      check("rst_we3_drop", we3, 0);
      check("rst_carry_drop", carry, 0);
      check("rst_zero", zero, 0);
      check("rst_no_done", done, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mcarry = 0;
      mzero  = 0;
      for (int k = 0; k < 3; k++) begin
         check("post_rst_no_done", done, 0);
         check("post_rst_ready", instr_ready, 1);
         @(negedge clk);
      end
      check("r7_kept", rf[7], 8'h11);

      for (int n = 0; n < 60; n++) begin
         issue(16'($urandom), 0, 16'h0);
      end

      repeat (3) @(negedge clk);
      for (int r = 0; r < 8; r++) begin
         check("final_reg", rf[r], mreg[r]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
